rbm_sequencer: RTL and testbench
================================

RBM_SEQUENCER -- requirements
Module: rbm_sequencer

Interface
REQ-001 SHALL have parameter N_VIS, 784, visible pixels per image.
REQ-002 SHALL have parameter N_HID, 441, hidden units.
REQ-003 SHALL have parameter N_CLS, 10, classifier outputs.
REQ-004 SHALL have parameter ITER, 100, sampling iterations per image.
REQ-005 SHALL have parameter W, 12, weight/bias width.
REQ-006 SHALL have port clock  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low.
REQ-008 SHALL have port start  in  1  begin classification of the current image.
REQ-009 SHALL have port pixel_in  in  1  image bit at pix_addr (combinational memory read).
REQ-010 SHALL have ports h_weight_in, h_bias_in, c_weight_in, c_bias_in  in  W  memory data at the current addresses.
REQ-011 SHALL have ports pix_addr  out  10, hid_addr  out  9, cls_addr  out  4  memory addresses, driven combinationally from the internal counters.
REQ-012 SHALL have ports Hvalue, Cvalue  out  W  and pixel, hidden_pixel  out  1  registered operands to the datapath.
REQ-013 SHALL have ports enable_hidden, enable_classi  out  1  datapath layer enables.
REQ-014 SHALL have ports hidden, hidden_finish, spike, finish  in  1  datapath results.
REQ-015 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), winner  out  4 (argmax class).
REQ-016 SHALL have ports rd_cls  in  4 and rd_count  out  7 (combinational read of spike counter rd_cls).

Function
REQ-017 SHALL implement states IDLE, HID, HID_WAIT, CLS, CLS_WAIT, ARGMAX and DONE.
REQ-018 IDLE/DONE + start SHALL clear all spike counters, the iteration counter and pix/hid/cls counters, then enter HID; start in any other state SHALL be ignored.
REQ-019 HID, counter p=0..N_VIS: each edge SHALL register pixel<=pixel_in and Hvalue<=h_weight_in for p<N_VIS, or pixel<=1 and Hvalue<=h_bias_in for p=N_VIS; p SHALL then increment; after p=N_VIS the state SHALL go to HID_WAIT.
REQ-020 HID_WAIT + hidden_finish SHALL store hidden into internal hbuf[hid] and set p=0; if hid=N_HID-1 the state SHALL go to CLS with hid=0, else hid increments and the state returns to HID.
REQ-021 CLS, counter h=0..N_HID: each edge SHALL register hidden_pixel<=hbuf[h] and Cvalue<=c_weight_in for h<N_HID, or hidden_pixel<=1 and Cvalue<=c_bias_in for h=N_HID; the state SHALL then go to CLS_WAIT.
REQ-022 CLS_WAIT + finish SHALL add spike to count[cls], saturating at 127; if cls=N_CLS-1, the iteration counter SHALL increment and the state SHALL go to ARGMAX when the counter reaches ITER, else to HID; otherwise cls increments and the state returns to CLS.
REQ-023 hidden_finish outside HID_WAIT and finish outside CLS_WAIT SHALL be ignored.
REQ-024 enable_hidden SHALL be 1 exactly in HID and HID_WAIT; enable_classi SHALL be 1 exactly in CLS and CLS_WAIT.
REQ-025 ARGMAX SHALL scan count[0..N_CLS-1] one per cycle (N_CLS cycles), keeping the maximum with the lowest index winning ties, then SHALL load winner and enter DONE.
REQ-026 DONE SHALL assert done for exactly one cycle on entry; winner and counts SHALL hold until the next accepted start.
REQ-027 busy SHALL be 1 in every state except IDLE and DONE.
REQ-028 Operand outputs SHALL hold their last value when not being loaded.

Reset
REQ-029 reset low SHALL immediately force IDLE, clear all counters, hbuf, operands, enables, busy, done, and set winner=0, including mid-operation.
REQ-030 After reset release, the block SHALL remain in IDLE until start.

Verification
REQ-031 Parameters N_VIS=4, N_HID=3, N_CLS=2, ITER=2; start -> enable_hidden rises next cycle; Hvalue sequence w0..w3, then bias; hid_addr advances only after hidden_finish.
REQ-032 Same parameters, hidden returns 1,0,1 -> hidden_pixel stream in CLS is 1,0,1,1 (bias).
REQ-033 spike=1 for class 1 only, both iterations -> count[1]=2, count[0]=0, winner=1, done pulse of one cycle, busy=0 afterwards.
REQ-034 Equal counts (2,2) -> winner=0.
REQ-035 reset asserted during CLS_WAIT -> all outputs 0 asynchronously; a new start reruns cleanly with counts starting at 0.
REQ-036 start pulsed while busy, and finish pulsed during HID -> no state or counter change.

Source files
------------

// File: rtl/rbm_sequencer_if.sv
// Memory and datapath signals between the RBM sequencer (master) and its
// weight/pixel memories plus the sampling datapath (slave).
interface rbm_sequencer_if #(
   parameter int unsigned W = 12
);
   logic          pixel_in;
   logic [W-1:0]  h_weight_in;
   logic [W-1:0]  h_bias_in;
   logic [W-1:0]  c_weight_in;
   logic [W-1:0]  c_bias_in;
   logic [9:0]    pix_addr;
   logic [8:0]    hid_addr;
   logic [3:0]    cls_addr;
   logic [W-1:0]  Hvalue;
   logic [W-1:0]  Cvalue;
   logic          pixel;
   logic          hidden_pixel;
   logic          enable_hidden;
   logic          enable_classi;
   logic          hidden;
   logic          hidden_finish;
   logic          spike;
   logic          finish;

   modport master (
      input  pixel_in, h_weight_in, h_bias_in, c_weight_in, c_bias_in,
      input  hidden, hidden_finish, spike, finish,
      output pix_addr, hid_addr, cls_addr,
      output Hvalue, Cvalue, pixel, hidden_pixel, enable_hidden, enable_classi
   );

   modport slave (
      output pixel_in, h_weight_in, h_bias_in, c_weight_in, c_bias_in,
      output hidden, hidden_finish, spike, finish,
      input  pix_addr, hid_addr, cls_addr,
      input  Hvalue, Cvalue, pixel, hidden_pixel, enable_hidden, enable_classi
   );
endinterface

// File: rtl/rbm_sequencer.sv
// Sequences one RBM classification: hidden-layer sweeps, classifier sweeps and
// spike counting over ITER iterations, then an argmax over the spike counts.
module rbm_sequencer #(
   parameter int unsigned N_VIS = 784,
   parameter int unsigned N_HID = 441,
   parameter int unsigned N_CLS = 10,
   parameter int unsigned ITER  = 100,
   parameter int unsigned W     = 12
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [3:0]    rd_cls,
   output logic          busy,
   output logic          done,
   output logic [3:0]    winner,
   output logic [6:0]    rd_count,
   rbm_sequencer_if.master bus
);

   localparam int unsigned P_W  = $clog2(N_VIS + 1);
   localparam int unsigned H_W  = $clog2(N_HID + 1);
   localparam int unsigned HI_W = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int unsigned CI_W = (N_CLS > 1) ? $clog2(N_CLS) : 1;
   localparam int unsigned I_W  = $clog2(ITER + 1);
   localparam int unsigned C_W  = 7;

   localparam logic [P_W-1:0] P_LAST   = P_W'(N_VIS);
   localparam logic [H_W-1:0] H_TOP    = H_W'(N_HID - 1);
   localparam logic [H_W-1:0] H_LAST   = H_W'(N_HID);
   localparam logic [3:0]     CLS_TOP  = 4'(N_CLS - 1);
   localparam logic [I_W-1:0] ITER_TOP = I_W'(ITER - 1);
   localparam logic [C_W-1:0] C_MAX    = '1;

   typedef enum logic [2:0] {
      IDLE, HID, HID_WAIT, CLS, CLS_WAIT, ARGMAX, DONE
   } state_t;

   state_t          state, state_nxt;
   logic            busy_nxt, done_nxt, en_hid_nxt, en_cls_nxt;

   logic [P_W-1:0]  p;
   logic [H_W-1:0]  hid;
   logic [3:0]      cls;
   logic [I_W-1:0]  iter;
   logic [N_HID-1:0] hbuf;
   logic [C_W-1:0]  count [N_CLS];
   logic [C_W-1:0]  best_val;
   logic [3:0]      best_idx;

   logic [W-1:0]    hvalue_q, cvalue_q;
   logic            pixel_q, hidden_pixel_q, en_hid_q, en_cls_q;

   logic [C_W-1:0]  scan_val_c;
   logic            take_c;
   logic [C_W-1:0]  cand_val_c;
   logic [3:0]      cand_idx_c;

   assign bus.pix_addr      = 10'(p);
   assign bus.hid_addr      = 9'(hid);
   assign bus.cls_addr      = cls;
   assign bus.Hvalue        = hvalue_q;
   assign bus.Cvalue        = cvalue_q;
   assign bus.pixel         = pixel_q;
   assign bus.hidden_pixel  = hidden_pixel_q;
   assign bus.enable_hidden = en_hid_q;
   assign bus.enable_classi = en_cls_q;

   assign rd_count = (int'(rd_cls) < int'(N_CLS)) ? count[CI_W'(rd_cls)] : '0;

   // Running argmax: first entry always taken, later ones only if strictly larger
   always_comb begin
      scan_val_c = count[CI_W'(cls)];
      take_c     = (cls == 4'd0) || (scan_val_c > best_val);
      cand_val_c = take_c ? scan_val_c : best_val;
      cand_idx_c = take_c ? cls : best_idx;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      en_hid_nxt = 1'b0;
      en_cls_nxt = 1'b0;
      unique case (state)
         IDLE, DONE: if (start) state_nxt = HID;
         HID:        if (p == P_LAST) state_nxt = HID_WAIT;
         HID_WAIT:   if (bus.hidden_finish) state_nxt = (hid == H_TOP) ? CLS : HID;
         CLS:        if (hid == H_LAST) state_nxt = CLS_WAIT;
         CLS_WAIT: begin
            if (bus.finish) begin
               if (cls != CLS_TOP)        state_nxt = CLS;
               else if (iter == ITER_TOP) state_nxt = ARGMAX;
               else                       state_nxt = HID;
            end
         end
         ARGMAX:     if (cls == CLS_TOP) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      busy_nxt   = !(state_nxt inside {IDLE, DONE});
      en_hid_nxt = state_nxt inside {HID, HID_WAIT};
      en_cls_nxt = state_nxt inside {CLS, CLS_WAIT};
      done_nxt   = (state_nxt == DONE) && (state != DONE);
   end

   // Counters, hidden buffer, spike counts and registered datapath operands
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         winner         <= '0;
         en_hid_q       <= 1'b0;
         en_cls_q       <= 1'b0;
         p              <= '0;
         hid            <= '0;
         cls            <= '0;
         iter           <= '0;
         hbuf           <= '0;
         best_val       <= '0;
         best_idx       <= '0;
         hvalue_q       <= '0;
         cvalue_q       <= '0;
         pixel_q        <= 1'b0;
         hidden_pixel_q <= 1'b0;
         for (int i = 0; i < int'(N_CLS); i++) count[i] <= '0;
      end else begin
         busy     <= busy_nxt;
         done     <= done_nxt;
         en_hid_q <= en_hid_nxt;
         en_cls_q <= en_cls_nxt;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  p    <= '0;
                  hid  <= '0;
                  cls  <= '0;
                  iter <= '0;
                  for (int i = 0; i < int'(N_CLS); i++) count[i] <= '0;
               end
            end
            HID: begin
               if (p == P_LAST) begin
                  pixel_q  <= 1'b1;
                  hvalue_q <= bus.h_bias_in;
               end else begin
                  pixel_q  <= bus.pixel_in;
                  hvalue_q <= bus.h_weight_in;
                  p        <= p + 1'b1;
               end
            end
            HID_WAIT: begin
               if (bus.hidden_finish) begin
                  hbuf[HI_W'(hid)] <= bus.hidden;
                  p                <= '0;
                  hid              <= (hid == H_TOP) ? '0 : hid + 1'b1;
               end
            end
            CLS: begin
               if (hid == H_LAST) begin
                  hidden_pixel_q <= 1'b1;
                  cvalue_q       <= bus.c_bias_in;
               end else begin
                  hidden_pixel_q <= hbuf[HI_W'(hid)];
                  cvalue_q       <= bus.c_weight_in;
                  hid            <= hid + 1'b1;
               end
            end
            CLS_WAIT: begin
               if (bus.finish) begin
                  if (count[CI_W'(cls)] != C_MAX)
                     count[CI_W'(cls)] <= count[CI_W'(cls)] + C_W'(bus.spike);
                  hid <= '0;
                  if (cls == CLS_TOP) begin
                     cls  <= '0;
                     iter <= iter + 1'b1;
                  end else begin
                     cls <= cls + 1'b1;
                  end
               end
            end
            ARGMAX: begin
               best_val <= cand_val_c;
               best_idx <= cand_idx_c;
               if (cls == CLS_TOP) begin
                  winner <= cand_idx_c;
                  cls    <= '0;
               end else begin
                  cls <= cls + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rbm_sequencer.sv
// Directed bench for rbm_sequencer with a tiny network (4 pixels, 3 hidden,
// 2 classes, 2 iterations); memories are modelled as address-derived patterns.
module tb_rbm_sequencer;

   localparam int unsigned N_VIS = 4;
   localparam int unsigned N_HID = 3;
   localparam int unsigned N_CLS = 2;
   localparam int unsigned ITER  = 2;
   localparam int unsigned W     = 12;

   logic       clock  = 1'b0;
   logic       reset  = 1'b0;
   logic       start  = 1'b0;
   logic [3:0] rd_cls = 4'd0;
   logic       busy, done;
   logic [3:0] winner;
   logic [6:0] rd_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] pix_mem = 4'b0110;

   rbm_sequencer_if #(.W(W)) bus ();

   rbm_sequencer #(
      .N_VIS(N_VIS), .N_HID(N_HID), .N_CLS(N_CLS), .ITER(ITER), .W(W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .rd_cls   (rd_cls),
      .busy     (busy),
      .done     (done),
      .winner   (winner),
      .rd_count (rd_count),
      .bus      (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [W-1:0] hw(input int h, input int p);
      return W'(16 * h + p + 1);
   endfunction
   function automatic logic [W-1:0] hb(input int h);
      return W'(32'h800 + h);
   endfunction
   function automatic logic [W-1:0] cw(input int c, input int h);
      return W'(256 * (c + 1) + h);
   endfunction
   function automatic logic [W-1:0] cb(input int c);
      return W'(32'h900 + c);
   endfunction

   assign bus.pixel_in    = pix_mem[bus.pix_addr[1:0]];
   assign bus.h_weight_in = hw(int'(bus.hid_addr), int'(bus.pix_addr));
   assign bus.h_bias_in   = hb(int'(bus.hid_addr));
   assign bus.c_weight_in = cw(int'(bus.cls_addr), int'(bus.hid_addr));
   assign bus.c_bias_in   = cb(int'(bus.cls_addr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic hid_phase(input int j, input logic hv, input bit inject);
      check("hid_addr_enter", 32'(bus.hid_addr), 32'(j));
      for (int k = 0; k < int'(N_VIS); k++) begin
         if (inject && k == 1) begin
            bus.finish = 1'b1;
            start      = 1'b1;
         end
         tick();
         bus.finish = 1'b0;
         start      = 1'b0;
         check("hvalue_w", 32'(bus.Hvalue), 32'(hw(j, k)));
         check("pixel", 32'(bus.pixel), 32'(pix_mem[k]));
      end
      tick();
      check("hvalue_bias", 32'(bus.Hvalue), 32'(hb(j)));
      check("pixel_bias", 32'(bus.pixel), 32'd1);
      tick();
      check("hid_addr_wait", 32'(bus.hid_addr), 32'(j));
      check("hvalue_hold", 32'(bus.Hvalue), 32'(hb(j)));
      check("en_hidden_wait", 32'(bus.enable_hidden), 32'd1);
      bus.hidden        = hv;
      bus.hidden_finish = 1'b1;
      tick();
      bus.hidden_finish = 1'b0;
      bus.hidden        = 1'b0;
   endtask

   task automatic cls_phase(input int c, input logic [2:0] hbits, input logic s, input bit inject);
      check("cls_addr", 32'(bus.cls_addr), 32'(c));
      check("en_classi", 32'(bus.enable_classi), 32'd1);
      check("en_hidden_off", 32'(bus.enable_hidden), 32'd0);
      for (int h = 0; h < int'(N_HID); h++) begin
         if (inject && h == 0) begin
            bus.hidden_finish = 1'b1;
            bus.hidden        = ~hbits[0];
         end
         tick();
         bus.hidden_finish = 1'b0;
         bus.hidden        = 1'b0;
         check("hidden_pixel", 32'(bus.hidden_pixel), 32'(hbits[h]));
         check("cvalue_w", 32'(bus.Cvalue), 32'(cw(c, h)));
      end
      tick();
      check("hidden_pixel_bias", 32'(bus.hidden_pixel), 32'd1);
      check("cvalue_bias", 32'(bus.Cvalue), 32'(cb(c)));
      tick();
      check("cvalue_hold", 32'(bus.Cvalue), 32'(cb(c)));
      bus.spike  = s;
      bus.finish = 1'b1;
      tick();
      bus.finish = 1'b0;
      bus.spike  = 1'b0;
   endtask

   // spk bit (it*N_CLS + c) is the spike returned for class c in iteration it
   task automatic run_image(input logic [2:0] hbits, input logic [3:0] spk,
                            input int e0, input int e1, input int ew);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_en_hidden", 32'(bus.enable_hidden), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
      check("start_pix_addr", 32'(bus.pix_addr), 32'd0);
      rd_cls = 4'd1;
      #1;
      check("start_count1_clear", 32'(rd_count), 32'd0);
      for (int it = 0; it < int'(ITER); it++) begin
         for (int j = 0; j < int'(N_HID); j++)
            hid_phase(j, hbits[j], (it == 0) && (j == 1));
         for (int c = 0; c < int'(N_CLS); c++)
            cls_phase(c, hbits, spk[it * int'(N_CLS) + c], (it == 0) && (c == 0));
      end
      tick();
      check("argmax_busy", 32'(busy), 32'd1);
      check("argmax_done", 32'(done), 32'd0);
      tick();
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("winner", 32'(winner), 32'(ew));
      tick();
      check("done_low", 32'(done), 32'd0);
      check("winner_hold", 32'(winner), 32'(ew));
      rd_cls = 4'd0;
      #1;
      check("count0", 32'(rd_count), 32'(e0));
      rd_cls = 4'd1;
      #1;
      check("count1", 32'(rd_count), 32'(e1));
   endtask

   initial begin
      bus.hidden        = 1'b0;
      bus.hidden_finish = 1'b0;
      bus.spike         = 1'b0;
      bus.finish        = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_winner", 32'(winner), 32'd0);
      check("rst_en_hidden", 32'(bus.enable_hidden), 32'd0);
      check("rst_hvalue", 32'(bus.Hvalue), 32'd0);

      @(negedge clock);
      reset = 1'b1;
      repeat (3) tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_en_hidden", 32'(bus.enable_hidden), 32'd0);

      // tie 2,2 -> lowest index wins
      run_image(3'b010, 4'b1111, 2, 2, 0);
      // hidden 1,0,1 and class 1 spiking both iterations
      run_image(3'b101, 4'b1010, 0, 2, 1);

      // abort mid-run from CLS_WAIT with an asynchronous reset
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < int'(N_HID); j++) hid_phase(j, 1'b1, 1'b0);
      repeat (N_HID + 2) tick();
      check("pre_rst_en_classi", 32'(bus.enable_classi), 32'd1);
      #3;
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_en_classi", 32'(bus.enable_classi), 32'd0);
      check("arst_cvalue", 32'(bus.Cvalue), 32'd0);
      check("arst_hidden_pixel", 32'(bus.hidden_pixel), 32'd0);
      check("arst_hvalue", 32'(bus.Hvalue), 32'd0);
      check("arst_pixel", 32'(bus.pixel), 32'd0);
      check("arst_winner", 32'(winner), 32'd0);
      check("arst_hid_addr", 32'(bus.hid_addr), 32'd0);
      rd_cls = 4'd1;
      #1;
      check("arst_count1", 32'(rd_count), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) tick();
      check("post_rst_idle", 32'(busy), 32'd0);

      // clean rerun: class 0 spikes once
      run_image(3'b110, 4'b0001, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
